// File: rtl/vc_state_ctrl_pkg.sv
// Shared router types and width helpers for the per-port VC state tracker.
// Imported by the VC state interface, the per-VC FSM and the vc_state_ctrl top.
package router_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      VC_ALLOC = 2'd1,
      ACTIVE   = 2'd2
   } vc_state_t;

   localparam int NUM_VC_DEF    = 4;
   localparam int NUM_PORTS_DEF = 4;
   localparam int BUF_DEPTH_DEF = 4;

   function automatic int portBitsFor(input int numPorts);
      return (numPorts <= 1) ? 1 : $clog2(numPorts);
   endfunction

   function automatic int vcBitsFor(input int numVc);
      return (numVc <= 1) ? 1 : $clog2(numVc);
   endfunction

   function automatic int cntBitsFor(input int bufDepth);
      return $clog2(bufDepth + 1);
   endfunction

endpackage

// File: rtl/vc_state_ctrl_if.sv
// Flit/grant inputs and per-VC status outputs of vc_state_ctrl.
// The master side drives flit and grant events; the slave side is the tracker.
interface vc_state_ctrl_if
   import router_pkg::*;
#(
   parameter int NUM_VC    = NUM_VC_DEF,
   parameter int NUM_PORTS = NUM_PORTS_DEF,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF
);
   localparam int PORT_BITS = portBitsFor(NUM_PORTS);
   localparam int VC_BITS   = vcBitsFor(NUM_VC);
   localparam int CNT_BITS  = cntBitsFor(BUF_DEPTH);

   logic                 flit_in_valid;
   logic [VC_BITS-1:0]   flit_in_vc;
   logic                 flit_in_head;
   logic [PORT_BITS-1:0] flit_in_dir;
   logic                 flit_out_valid;
   logic [VC_BITS-1:0]   flit_out_vc;
   logic                 flit_out_tail;
   logic                 vc_grant_valid;
   logic [VC_BITS-1:0]   vc_grant_vc;
   logic [VC_BITS-1:0]   vc_grant_out_vc;

   logic [NUM_VC-1:0][PORT_BITS-1:0] vc_direction;
   logic [NUM_VC-1:0]                vc_req;
   logic [NUM_VC-1:0]                vc_active;
   logic [NUM_VC-1:0][VC_BITS-1:0]   vc_out_vc;
   logic [NUM_VC-1:0][CNT_BITS-1:0]  vc_count;
   logic [NUM_VC-1:0]                vc_full;
   logic [NUM_VC-1:0]                vc_empty;
   logic [NUM_VC-1:0]                vc_err;

   modport master (
      output flit_in_valid, flit_in_vc, flit_in_head, flit_in_dir,
      output flit_out_valid, flit_out_vc, flit_out_tail,
      output vc_grant_valid, vc_grant_vc, vc_grant_out_vc,
      input  vc_direction, vc_req, vc_active, vc_out_vc,
      input  vc_count, vc_full, vc_empty, vc_err
   );

   modport slave (
      input  flit_in_valid, flit_in_vc, flit_in_head, flit_in_dir,
      input  flit_out_valid, flit_out_vc, flit_out_tail,
      input  vc_grant_valid, vc_grant_vc, vc_grant_out_vc,
      output vc_direction, vc_req, vc_active, vc_out_vc,
      output vc_count, vc_full, vc_empty, vc_err
   );

endinterface

// File: rtl/vc_state_ctrl_fsm.sv
// One virtual channel: packet FSM, latched direction/out-VC, occupancy counter
// and sticky error bit (error logic present only with VC_STATE_ERR_EN).
module vc_state_fsm
   import router_pkg::*;
#(
   parameter int NUM_VC    = NUM_VC_DEF,
   parameter int NUM_PORTS = NUM_PORTS_DEF,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 wr_i,
   input  logic                                 head_i,
   input  logic [portBitsFor(NUM_PORTS)-1:0]    dir_i,
   input  logic                                 dep_i,
   input  logic                                 tail_i,
   input  logic                                 grant_i,
   input  logic [vcBitsFor(NUM_VC)-1:0]         grantOutVc_i,
   output logic [portBitsFor(NUM_PORTS)-1:0]    dir_o,
   output logic [vcBitsFor(NUM_VC)-1:0]         outVc_o,
   output logic [cntBitsFor(BUF_DEPTH)-1:0]     count_o,
   output logic                                 req_o,
   output logic                                 active_o,
   output logic                                 full_o,
   output logic                                 empty_o,
   output logic                                 err_o
);
   localparam int PORT_BITS = portBitsFor(NUM_PORTS);
   localparam int VC_BITS   = vcBitsFor(NUM_VC);
   localparam int CNT_BITS  = cntBitsFor(BUF_DEPTH);

   vc_state_t            state_q, state_d;
   logic [PORT_BITS-1:0] dir_q, dir_d;
   logic [VC_BITS-1:0]   outVc_q, outVc_d;
   logic [CNT_BITS-1:0]  count_q, count_d;

   logic isFull, isEmpty, wrOk, depOk, headIn, tailOut;

   // A write into a full buffer or a departure from an empty one never happened
   // as far as occupancy and packet state are concerned.
   assign isFull  = (count_q == CNT_BITS'(BUF_DEPTH));
   assign isEmpty = (count_q == '0);
   assign wrOk    = wr_i && !isFull;
   assign depOk   = dep_i && !isEmpty;
   assign headIn  = wrOk && head_i;
   assign tailOut = depOk && tail_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         dir_q   <= '0;
         outVc_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         outVc_q <= outVc_d;
         count_q <= count_d;
      end
   end

   // A stray head outside IDLE freezes the FSM, so the grant is not taken then.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      outVc_d = outVc_q;
      case (state_q)
         IDLE: begin
            if (headIn) begin
               state_d = VC_ALLOC;
               dir_d   = dir_i;
            end
         end
         VC_ALLOC: begin
            if (!headIn && grant_i) begin
               state_d = ACTIVE;
               outVc_d = grantOutVc_i;
            end
         end
         ACTIVE: begin
            if (tailOut) begin
               if (headIn) begin
                  state_d = VC_ALLOC;
                  dir_d   = dir_i;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (wrOk && !depOk) begin
         count_d = count_q + CNT_BITS'(1);
      end else if (depOk && !wrOk) begin
         count_d = count_q - CNT_BITS'(1);
      end
   end

`ifdef VC_STATE_ERR_EN
   logic err_q, headErr;

   assign headErr = headIn && (state_q != IDLE) && !((state_q == ACTIVE) && tailOut);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q || headErr || (wr_i && isFull) || (dep_i && isEmpty);
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign dir_o    = dir_q;
   assign outVc_o  = outVc_q;
   assign count_o  = count_q;
   assign req_o    = (state_q == VC_ALLOC);
   assign active_o = (state_q == ACTIVE);
   assign full_o   = isFull;
   assign empty_o  = isEmpty;

endmodule

// File: rtl/vc_state_ctrl.sv
// Per-input-port VC state tracker feeding select_vc; one vc_state_fsm per VC.
// Define VC_STATE_ERR_EN to build the sticky per-VC protocol error flags.
module vc_state_ctrl
   import router_pkg::*;
#(
   parameter int NUM_VC    = NUM_VC_DEF,
   parameter int NUM_PORTS = NUM_PORTS_DEF,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            reset,
   vc_state_ctrl_if.slave  bus
);
   localparam int PORT_BITS = portBitsFor(NUM_PORTS);
   localparam int VC_BITS   = vcBitsFor(NUM_VC);
   localparam int CNT_BITS  = cntBitsFor(BUF_DEPTH);

   logic [NUM_VC-1:0][PORT_BITS-1:0] dirVec;
   logic [NUM_VC-1:0][VC_BITS-1:0]   outVcVec;
   logic [NUM_VC-1:0][CNT_BITS-1:0]  countVec;
   logic [NUM_VC-1:0]                reqVec, activeVec, fullVec, emptyVec, errVec;

   // Each VC sees only the write, departure and grant strobes addressed to it.
   for (genvar v = 0; v < NUM_VC; v++) begin : gVc
      logic wrHit, depHit, grantHit;

      assign wrHit    = bus.flit_in_valid  && (bus.flit_in_vc  == VC_BITS'(v));
      assign depHit   = bus.flit_out_valid && (bus.flit_out_vc == VC_BITS'(v));
      assign grantHit = bus.vc_grant_valid && (bus.vc_grant_vc == VC_BITS'(v));

      vc_state_fsm #(
         .NUM_VC    (NUM_VC),
         .NUM_PORTS (NUM_PORTS),
         .BUF_DEPTH (BUF_DEPTH)
      ) uFsm (
         .clk          (clk),
         .reset        (reset),
         .wr_i         (wrHit),
         .head_i       (bus.flit_in_head),
         .dir_i        (bus.flit_in_dir),
         .dep_i        (depHit),
         .tail_i       (bus.flit_out_tail),
         .grant_i      (grantHit),
         .grantOutVc_i (bus.vc_grant_out_vc),
         .dir_o        (dirVec[v]),
         .outVc_o      (outVcVec[v]),
         .count_o      (countVec[v]),
         .req_o        (reqVec[v]),
         .active_o     (activeVec[v]),
         .full_o       (fullVec[v]),
         .empty_o      (emptyVec[v]),
         .err_o        (errVec[v])
      );
   end

   assign bus.vc_direction = dirVec;
   assign bus.vc_out_vc    = outVcVec;
   assign bus.vc_count     = countVec;
   assign bus.vc_req       = reqVec;
   assign bus.vc_active    = activeVec;
   assign bus.vc_full      = fullVec;
   assign bus.vc_empty     = emptyVec;
   assign bus.vc_err       = errVec;

endmodule

// File: tb/tb_vc_state_ctrl.sv
// Self-checking bench for vc_state_ctrl: directed vector table, corner-case
// sequences, then random traffic against a packet-level reference model.
module tb_vc_state_ctrl;

   localparam int NV = 4;
   localparam int NP = 4;
   localparam int BD = 4;
`ifdef VC_STATE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_WAIT  = 1;
   localparam int M_OWNED = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checkCount = 0;
   int   passCount = 0;

   vc_state_ctrl_if #(.NUM_VC(NV), .NUM_PORTS(NP), .BUF_DEPTH(BD)) vcIf ();

   vc_state_ctrl #(.NUM_VC(NV), .NUM_PORTS(NP), .BUF_DEPTH(BD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vcIf.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       wv;
      bit [1:0] wvc;
      bit       wh;
      bit [1:0] wdir;
      bit       dv;
      bit [1:0] dvc;
      bit       dt;
      bit       gv;
      bit [1:0] gvc;
      bit [1:0] gout;
      bit [3:0] expReq;
      bit [3:0] expActive;
      bit [3:0] expFull;
      bit [3:0] expEmpty;
   } vec_t;

   vec_t vecs[8];

   // Reference model: per-VC packet phase, buffered flit count, latched fields.
   int       mPhase[NV];
   int       mFlits[NV];
   bit [1:0] mDir[NV];
   bit [1:0] mOut[NV];
   bit       mErr[NV];

   bit       rwv, rwh, rdv, rdt, rgv;
   bit [1:0] rwvc, rwdir, rdvc, rgvc, rgout;

   function automatic vec_t mkVec(bit wv, bit [1:0] wvc, bit wh, bit [1:0] wdir,
                                  bit dv, bit [1:0] dvc, bit dt,
                                  bit gv, bit [1:0] gvc, bit [1:0] gout,
                                  bit [3:0] er, bit [3:0] ea, bit [3:0] ef, bit [3:0] ee);
      vec_t r;
      r.wv = wv; r.wvc = wvc; r.wh = wh; r.wdir = wdir;
      r.dv = dv; r.dvc = dvc; r.dt = dt;
      r.gv = gv; r.gvc = gvc; r.gout = gout;
      r.expReq = er; r.expActive = ea; r.expFull = ef; r.expEmpty = ee;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic setIdle();
      vcIf.flit_in_valid   = 1'b0;
      vcIf.flit_in_vc      = '0;
      vcIf.flit_in_head    = 1'b0;
      vcIf.flit_in_dir     = '0;
      vcIf.flit_out_valid  = 1'b0;
      vcIf.flit_out_vc     = '0;
      vcIf.flit_out_tail   = 1'b0;
      vcIf.vc_grant_valid  = 1'b0;
      vcIf.vc_grant_vc     = '0;
      vcIf.vc_grant_out_vc = '0;
   endtask

   task automatic applyStimulus(input bit wv, input bit [1:0] wvc, input bit wh, input bit [1:0] wdir,
                                input bit dv, input bit [1:0] dvc, input bit dt,
                                input bit gv, input bit [1:0] gvc, input bit [1:0] gout);
      @(negedge clk);
      vcIf.flit_in_valid   = wv;
      vcIf.flit_in_vc      = wvc;
      vcIf.flit_in_head    = wh;
      vcIf.flit_in_dir     = wdir;
      vcIf.flit_out_valid  = dv;
      vcIf.flit_out_vc     = dvc;
      vcIf.flit_out_tail   = dt;
      vcIf.vc_grant_valid  = gv;
      vcIf.vc_grant_vc     = gvc;
      vcIf.vc_grant_out_vc = gout;
      @(posedge clk);
      #1;
      setIdle();
   endtask

   task automatic modelReset();
      for (int v = 0; v < NV; v++) begin
         mPhase[v] = M_IDLE; mFlits[v] = 0; mDir[v] = 0; mOut[v] = 0; mErr[v] = 0;
      end
   endtask

   task automatic modelStep();
      for (int v = 0; v < NV; v++) begin
         bit writeHere, leaveHere, grantHere, took, gave, headArrives, tailLeaves;
         writeHere = rwv && (rwvc == 2'(v));
         leaveHere = rdv && (rdvc == 2'(v));
         grantHere = rgv && (rgvc == 2'(v));
         took = writeHere && (mFlits[v] < BD);
         gave = leaveHere && (mFlits[v] > 0);
         if (writeHere && !took) mErr[v] = ERR_EN;
         if (leaveHere && !gave) mErr[v] = ERR_EN;
         headArrives = took && rwh;
         tailLeaves  = gave && rdt;
         mFlits[v] = mFlits[v] + (took ? 1 : 0) - (gave ? 1 : 0);
         if (mPhase[v] == M_IDLE) begin
            if (headArrives) begin mPhase[v] = M_WAIT; mDir[v] = rwdir; end
         end else if (mPhase[v] == M_WAIT) begin
            if (headArrives) mErr[v] = ERR_EN;
            else if (grantHere) begin mPhase[v] = M_OWNED; mOut[v] = rgout; end
         end else begin
            if (tailLeaves && headArrives) begin mPhase[v] = M_WAIT; mDir[v] = rwdir; end
            else if (tailLeaves) mPhase[v] = M_IDLE;
            else if (headArrives) mErr[v] = ERR_EN;
         end
      end
   endtask

   task automatic checkModel();
      logic [3:0] eReq, eAct, eFull, eEmpty, eErr;
      logic [7:0] eDir, eOut;
      logic [11:0] eCnt;
      for (int v = 0; v < NV; v++) begin
         eReq[v]   = (mPhase[v] == M_WAIT);
         eAct[v]   = (mPhase[v] == M_OWNED);
         eFull[v]  = (mFlits[v] == BD);
         eEmpty[v] = (mFlits[v] == 0);
         eErr[v]   = mErr[v];
         eDir[v*2 +: 2] = mDir[v];
         eOut[v*2 +: 2] = mOut[v];
         eCnt[v*3 +: 3] = 3'(mFlits[v]);
      end
      checkOutput("rnd_req",    32'(vcIf.vc_req),       32'(eReq));
      checkOutput("rnd_active", 32'(vcIf.vc_active),    32'(eAct));
      checkOutput("rnd_full",   32'(vcIf.vc_full),      32'(eFull));
      checkOutput("rnd_empty",  32'(vcIf.vc_empty),     32'(eEmpty));
      checkOutput("rnd_err",    32'(vcIf.vc_err),       32'(eErr));
      checkOutput("rnd_dir",    32'(vcIf.vc_direction), 32'(eDir));
      checkOutput("rnd_outvc",  32'(vcIf.vc_out_vc),    32'(eOut));
      checkOutput("rnd_count",  32'(vcIf.vc_count),     32'(eCnt));
   endtask

   initial begin
      setIdle();
      vecs[0] = mkVec(1, 2, 1, 2,  0, 0, 0,  0, 0, 0,  4'b0100, 4'b0000, 4'b0000, 4'b1011);
      vecs[1] = mkVec(0, 0, 0, 0,  0, 0, 0,  1, 2, 1,  4'b0000, 4'b0100, 4'b0000, 4'b1011);
      vecs[2] = mkVec(0, 0, 0, 0,  0, 0, 0,  1, 0, 3,  4'b0000, 4'b0100, 4'b0000, 4'b1011);
      vecs[3] = mkVec(1, 1, 0, 0,  0, 0, 0,  0, 0, 0,  4'b0000, 4'b0100, 4'b0000, 4'b1001);
      vecs[4] = mkVec(1, 1, 0, 0,  0, 0, 0,  0, 0, 0,  4'b0000, 4'b0100, 4'b0000, 4'b1001);
      vecs[5] = mkVec(1, 1, 0, 0,  0, 0, 0,  0, 0, 0,  4'b0000, 4'b0100, 4'b0000, 4'b1001);
      vecs[6] = mkVec(1, 1, 0, 0,  0, 0, 0,  0, 0, 0,  4'b0000, 4'b0100, 4'b0010, 4'b1001);
      vecs[7] = mkVec(1, 1, 0, 0,  0, 0, 0,  0, 0, 0,  4'b0000, 4'b0100, 4'b0010, 4'b1001);

      #12 reset = 1'b1;
      checkOutput("reset_req",   32'(vcIf.vc_req),   32'h0);
      checkOutput("reset_empty", 32'(vcIf.vc_empty), 32'hf);
      checkOutput("reset_count", 32'(vcIf.vc_count), 32'h0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].wv, vecs[i].wvc, vecs[i].wh, vecs[i].wdir,
                       vecs[i].dv, vecs[i].dvc, vecs[i].dt,
                       vecs[i].gv, vecs[i].gvc, vecs[i].gout);
         checkOutput($sformatf("vec%0d_req", i),    32'(vcIf.vc_req),    32'(vecs[i].expReq));
         checkOutput($sformatf("vec%0d_active", i), 32'(vcIf.vc_active), 32'(vecs[i].expActive));
         checkOutput($sformatf("vec%0d_full", i),   32'(vcIf.vc_full),   32'(vecs[i].expFull));
         checkOutput($sformatf("vec%0d_empty", i),  32'(vcIf.vc_empty),  32'(vecs[i].expEmpty));
      end
      checkOutput("table_count", 32'(vcIf.vc_count),        32'({3'd0, 3'd1, 3'd4, 3'd0}));
      checkOutput("table_dir2",  32'(vcIf.vc_direction[2]), 32'h2);
      checkOutput("table_out2",  32'(vcIf.vc_out_vc[2]),    32'h1);
      checkOutput("overflow_err", 32'(vcIf.vc_err), ERR_EN ? 32'h2 : 32'h0);

      // VC3: head, grant, then tail out and new head in the same cycle.
      applyStimulus(1, 3, 1, 3,  0, 0, 0,  0, 0, 0);
      checkOutput("vc3_req", 32'(vcIf.vc_req), 32'h8);
      applyStimulus(0, 0, 0, 0,  0, 0, 0,  1, 3, 2);
      checkOutput("vc3_active", 32'(vcIf.vc_active), 32'hc);
      applyStimulus(1, 3, 1, 1,  1, 3, 1,  0, 0, 0);
      checkOutput("vc3_rehead_req",    32'(vcIf.vc_req),          32'h8);
      checkOutput("vc3_rehead_active", 32'(vcIf.vc_active),       32'h4);
      checkOutput("vc3_rehead_dir",    32'(vcIf.vc_direction[3]), 32'h1);
      checkOutput("vc3_rehead_count",  32'(vcIf.vc_count[3]),     32'h1);
      checkOutput("vc3_rehead_err",    32'(vcIf.vc_err), ERR_EN ? 32'h2 : 32'h0);

      // Departure from an empty VC0.
      applyStimulus(0, 0, 0, 0,  1, 0, 0,  0, 0, 0);
      checkOutput("underflow_count", 32'(vcIf.vc_count[0]), 32'h0);
      checkOutput("underflow_empty", 32'(vcIf.vc_empty[0]), 32'h1);
      checkOutput("underflow_err",   32'(vcIf.vc_err), ERR_EN ? 32'h3 : 32'h0);

      // Independent write/depart on different VCs.
      applyStimulus(1, 0, 0, 0,  1, 1, 0,  0, 0, 0);
      checkOutput("indep1_count", 32'(vcIf.vc_count), 32'({3'd1, 3'd1, 3'd3, 3'd1}));
      applyStimulus(1, 1, 0, 0,  1, 2, 0,  0, 0, 0);
      checkOutput("indep2_count", 32'(vcIf.vc_count), 32'({3'd1, 3'd0, 3'd4, 3'd1}));
      checkOutput("indep2_active", 32'(vcIf.vc_active), 32'h4);

      // Asynchronous reset between edges.
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_req",    32'(vcIf.vc_req),       32'h0);
      checkOutput("async_active", 32'(vcIf.vc_active),    32'h0);
      checkOutput("async_full",   32'(vcIf.vc_full),      32'h0);
      checkOutput("async_empty",  32'(vcIf.vc_empty),     32'hf);
      checkOutput("async_count",  32'(vcIf.vc_count),     32'h0);
      checkOutput("async_dir",    32'(vcIf.vc_direction), 32'h0);
      checkOutput("async_outvc",  32'(vcIf.vc_out_vc),    32'h0);
      checkOutput("async_err",    32'(vcIf.vc_err),       32'h0);
      @(negedge clk);
      reset = 1'b1;

      modelReset();
      for (int c = 0; c < 600; c++) begin
         rwv   = ($urandom_range(0, 1) == 1);
         rwvc  = 2'($urandom_range(0, 3));
         rwh   = ($urandom_range(0, 3) == 0);
         rwdir = 2'($urandom_range(0, 3));
         rdv   = ($urandom_range(0, 1) == 1);
         rdvc  = 2'($urandom_range(0, 3));
         rdt   = ($urandom_range(0, 2) == 0);
         rgv   = ($urandom_range(0, 1) == 1);
         rgvc  = 2'($urandom_range(0, 3));
         rgout = 2'($urandom_range(0, 3));
         applyStimulus(rwv, rwvc, rwh, rwdir, rdv, rdvc, rdt, rgv, rgvc, rgout);
         modelStep();
         checkModel();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/vc_state_ctrl.md
# vc_state_ctrl

Per-input-port virtual-channel state tracker that sits directly upstream of `select_vc`. It tracks, for every VC of one input port, the packet state (idle / awaiting VC allocation / active), the routed output direction latched from the head flit, the allocated downstream VC, and buffer occupancy. Its `vc_direction` output drives the matching input of `select_vc`, and its `vc_req` vector qualifies which VCs are competing for allocation.

## Interface
- `NUM_VC`, 4, virtual channels per input port
- `NUM_PORTS`, 4, router ports; `PORT_BITS = $clog2(NUM_PORTS)`, `VC_BITS = $clog2(NUM_VC)`
- `BUF_DEPTH`, 4, flit slots per VC; `CNT_BITS = $clog2(BUF_DEPTH+1)`

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `flit_in_valid`  in  1  flit written into a VC buffer this cycle
- `flit_in_vc`  in  VC_BITS  target VC of the arriving flit
- `flit_in_head`  in  1  arriving flit is a head
- `flit_in_dir`  in  PORT_BITS  route-computed output direction (meaningful with head only)
- `flit_out_valid`  in  1  flit leaves a VC buffer through the switch this cycle
- `flit_out_vc`  in  VC_BITS  VC of the departing flit
- `flit_out_tail`  in  1  departing flit is a tail
- `vc_grant_valid`  in  1  VC allocator grant this cycle
- `vc_grant_vc`  in  VC_BITS  input VC receiving the grant
- `vc_grant_out_vc`  in  VC_BITS  downstream VC assigned
- `vc_direction`  out  [NUM_VC] x PORT_BITS  latched direction per VC
- `vc_req`  out  NUM_VC  VC is in VC_ALLOC state
- `vc_active`  out  NUM_VC  VC is in ACTIVE state
- `vc_out_vc`  out  [NUM_VC] x VC_BITS  assigned downstream VC per VC
- `vc_count`  out  [NUM_VC] x CNT_BITS  occupancy per VC
- `vc_full`  out  NUM_VC  count == BUF_DEPTH
- `vc_empty`  out  NUM_VC  count == 0
- `vc_err`  out  NUM_VC  sticky protocol error (see Configuration)

## Operation
- Per-VC FSM states: IDLE, VC_ALLOC, ACTIVE.
- IDLE: head write to this VC -> VC_ALLOC and latch `flit_in_dir` into `vc_direction`.
- VC_ALLOC: `vc_req` is high. A grant with `vc_grant_vc` equal to this VC moves it to ACTIVE and latches `vc_grant_out_vc`. A grant to a VC that is not in VC_ALLOC is ignored.
- ACTIVE: a tail departure from this VC moves it to IDLE. `vc_direction` and `vc_out_vc` hold their values, and are not cleared.
- Same-cycle tail departure and head write on the same VC: the head wins. The VC goes to VC_ALLOC and latches the new direction.
- Head write while the VC is not IDLE (and no same-cycle tail departure) is a protocol error:
  - the direction is not updated and the state is unchanged;
  - the flit is still counted.
- Occupancy per VC:
  - write only: +1;
  - depart only: −1;
  - write and depart on the same VC in the same cycle: unchanged.
- Write to a full VC: the flit is dropped, the count is unchanged, and it is an error.
- Departure from an empty VC: ignored, count stays 0, and it is an error.
- Writes and departures on different VCs in the same cycle are independent.

## Timing
- All outputs come from registers or from registered state. There is no combinational path from inputs to outputs.
- Head written in cycle N: `vc_req` and `vc_direction` are valid from N+1.
- Grant in cycle N: `vc_active` and `vc_out_vc` are valid from N+1, and `vc_req` drops at N+1.
- Tail departure in cycle N: the VC is IDLE at N+1.
- Values on asynchronous assertion of `reset` (low):
  - all FSMs go to IDLE;
  - `vc_direction`, `vc_out_vc`, `vc_count`, `vc_req`, `vc_active`, `vc_full` and `vc_err` go to 0;
  - `vc_empty` goes to all ones.
- Reset mid-packet discards all state. Deassertion takes effect at the next rising edge.

## Configuration
- `VC_STATE_ERR_EN` defined:
  - `vc_err[v]` sets on any protocol error for VC v: head while not IDLE, overflow, or underflow;
  - it stays set until reset.
- Not defined:
  - the error logic is compiled out and `vc_err` is tied to 0;
  - the error conditions keep the same drop/ignore behaviour.

## Structure
- The shared package `router_pkg` holds:
  - the `vc_state_t` enum (IDLE, VC_ALLOC, ACTIVE);
  - the width helper constants `PORT_BITS`, `VC_BITS`, `CNT_BITS` as parameterized functions or localparams.
- Sub-module `vc_state_fsm` holds one VC's FSM, direction/out-VC registers, counter and error bit. It is instantiated NUM_VC times under generate, with per-VC decoded write, depart and grant strobes.

## Test plan
- Reset, then head on VC2 with dir=2'b10 → at the next cycle `vc_req`=4'b0100, `vc_direction[2]`=2'b10, `vc_count[2]`=1.
- Grant vc=2, out_vc=1 → at the next cycle `vc_active[2]`=1, `vc_req[2]`=0, `vc_out_vc[2]`=1. A grant to VC0 while VC0 is IDLE → no change.
- Four writes to VC1 with BUF_DEPTH=4 → `vc_full[1]`=1. A fifth write → count stays 4, and `vc_err[1]`=1 if `VC_STATE_ERR_EN` is defined, else 0.
- VC3 ACTIVE with a tail departing while a new head (dir=2'b01) is written in the same cycle → VC3 in VC_ALLOC, `vc_direction[3]`=2'b01, count unchanged.
- Departure from empty VC0 → count 0, `vc_empty[0]`=1. Simultaneous write VC1 and depart VC2 → counts update independently.
- Assert `reset` low mid-packet between clock edges → outputs reach their reset values immediately, without waiting for a clock edge.
